sprite_line_compositor: RTL and testbench
=========================================

Name: sprite_line_compositor

Overview:
- Pixel-side stage directly downstream of the sprite shape reader.
- Consumes the 64×16-bit per-line shape bus it produces, plus the per-sprite X position, Y position and colour tables.
- Selects up to MAX_SLOTS sprites visible on each line, then outputs a registered per-pixel sprite colour and hit ID to the VGA mixer.
- Sprite selection happens during the previous line; sprite slots are loaded at the start of the line.

Parameters:
- MAX_SLOTS, 8, number of sprites renderable per line (1..16).
- EVAL_H, 640, H_pos value that starts the next-line evaluation scan.
- LOAD_H, 2, H_pos value at which slots are loaded from sprite_shape_in; the shape bus is stable by then.
- V_FIRST, 32, first visible line.
- V_LAST, 511, last visible line.
- H_ACTIVE, 640, active pixels per line (H_pos 0..H_ACTIVE-1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- V_pos_in  in  10  current line
- H_pos_in  in  10  current pixel
- sprite_shape_in  in  1024  sprite k, row for current line = [k*16 +: 16]; bit 15 is the leftmost pixel
- sprite_x  in  640  sprite k X = [k*10 +: 10]
- sprite_y  in  640  sprite k top line = [k*10 +: 10]; sprite covers lines y..y+15
- sprite_color  in  512  sprite k colour = [k*8 +: 8]
- pixel_valid  out  1  opaque sprite pixel present
- pixel_color  out  8  colour of winning sprite, 0 when not valid
- pixel_sprite_id  out  6  index of winning sprite, 0 when not valid
- line_overflow  out  1  more than MAX_SLOTS sprites were found for the current line
- frame_overflow  out  1  sticky; set if any line of the frame overflowed
- eval_state  out  2  FSM state, for debug

Behaviour:
- Reset (rst=0 at clk edge): FSM to S_IDLE; pending and active slot counts 0; all outputs 0.
- FSM states: S_IDLE=0, S_EVAL=1, S_HOLD=2.
- S_IDLE -> S_EVAL when H_pos_in==EVAL_H and V_FIRST-1 <= V_pos_in <= V_LAST-1.
  - On entry: clear pending count, clear line-pending overflow, set scan counter k=0.
- S_EVAL, one sprite per clock, k=0..63:
  - nl = V_pos_in+1, 10-bit.
  - Hit if nl >= y_k and nl - y_k <= 15; the subtraction is 10-bit unsigned, guarded by the >= check, so there is no wrap for y near 1023.
  - On a hit with pending count < MAX_SLOTS: store k in pending[count]; count++.
  - On a hit with pending count == MAX_SLOTS: set pending overflow; do not store k.
  - After k==63: go to S_HOLD. Scan length is exactly 64 clocks.
- S_HOLD -> S_IDLE when H_pos_in==LOAD_H.
  - If V_FIRST <= V_pos_in <= V_LAST: copy pending indices and count to the active set; latch shape, x and colour of each indexed sprite from the input buses in that same cycle; line_overflow <= pending overflow.
  - Otherwise: active count <= 0, line_overflow <= 0.
- If H_pos_in==LOAD_H is reached in S_IDLE (no evaluation ran, e.g. first visible line after reset), the active count loads 0.
- Inputs changing after LOAD_H do not affect the current line.
- Render (every clock, 1-cycle latency; outputs registered from the current H_pos_in):
  - For each active slot s < count: dx = H_pos_in - x_s.
  - Slot s hits if H_pos_in >= x_s, dx < 16 and shape_s[15-dx]==1.
  - The lowest-numbered hitting slot wins, which is the lowest sprite index.
  - Outputs are valid only when H_pos_in < H_ACTIVE and V_FIRST <= V_pos_in <= V_LAST; otherwise all 0.
  - A sprite with x > H_ACTIVE-16 is clipped at the right edge; there is no wrap to the left.
- frame_overflow: cleared on the clock where V_pos_in==0 and H_pos_in==0; set whenever line_overflow is loaded as 1. If both happen on the same clock, set wins.
- Reset asserted mid-scan aborts the scan; the next line renders with count 0.

Optional Feature:
- Macro SPRITE_COLLISION_DETECT_EN.
- When defined, add outputs:
  - collision_flag (1): sticky, set when at least two active slots hit the same pixel in the active region.
  - collision_id_a (6) and collision_id_b (6): the two lowest hitting sprite indices of the first collision in the frame.
  - All three are cleared at V=0,H=0 and on reset.
- When not defined, these ports are absent and no comparison logic is built.

Test Plan:
- Sprite 5: y=100, x=200, colour 0x3C, shape row 0xFFFF; line 100 -> pixel_valid=1, id=5, colour=0x3C for H=200..215 (outputs one clock after), 0 at H=199 and H=216.
- Sprites 3 and 9 both at x=50, y=40, all rows 0x8000; line 45, H=50 -> id=3 only. With SPRITE_COLLISION_DETECT_EN: collision_flag=1, ids 3/9.
- Ten sprites (0..9) at y=60 -> line 60: only sprites 0..7 render, line_overflow=1, frame_overflow=1 until the next V=0,H=0.
- Sprite at y=1020 (range wraps past 1023) and a sprite at y=511 with line 512 -> no hits, outputs 0; line 511 renders the y=511 sprite row 0.
- Sprite at x=630, row 0xFFFF -> valid for H=630..639 only, 0 at H>=640.
- rst=0 for one clock during S_EVAL on line 200 -> eval_state=0, line 201 outputs all 0, line 202 renders normally.

Source files
------------

// File: rtl/sprite_line_compositor.sv
// Sprite line compositor: scans all 64 sprites for the next line, loads up to MAX_SLOTS slots at LOAD_H,
// then renders a registered per-pixel colour/id. Define SPRITE_COLLISION_DETECT_EN to build collision detection.
module sprite_line_compositor #(
   parameter int MAX_SLOTS = 8,
   parameter int EVAL_H    = 640,
   parameter int LOAD_H    = 2,
   parameter int V_FIRST   = 32,
   parameter int V_LAST    = 511,
   parameter int H_ACTIVE  = 640
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [9:0]    V_pos_in,
   input  logic [9:0]    H_pos_in,
   input  logic [1023:0] sprite_shape_in,
   input  logic [639:0]  sprite_x,
   input  logic [639:0]  sprite_y,
   input  logic [511:0]  sprite_color,
   output logic          pixel_valid,
   output logic [7:0]    pixel_color,
   output logic [5:0]    pixel_sprite_id,
   output logic          line_overflow,
   output logic          frame_overflow,
`ifdef SPRITE_COLLISION_DETECT_EN
   output logic          collision_flag,
   output logic [5:0]    collision_id_a,
   output logic [5:0]    collision_id_b,
`endif
   output logic [1:0]    eval_state
);
   localparam int CW = $clog2(MAX_SLOTS + 1);
   localparam logic [9:0]    EVAL_H_L   = 10'(EVAL_H);
   localparam logic [9:0]    LOAD_H_L   = 10'(LOAD_H);
   localparam logic [9:0]    V_FIRST_L  = 10'(V_FIRST);
   localparam logic [9:0]    V_LAST_L   = 10'(V_LAST);
   localparam logic [9:0]    EVAL_LO_L  = 10'(V_FIRST - 1);
   localparam logic [9:0]    EVAL_HI_L  = 10'(V_LAST - 1);
   localparam logic [9:0]    H_ACTIVE_L = 10'(H_ACTIVE);
   localparam logic [CW-1:0] MAX_L      = CW'(MAX_SLOTS);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EVAL = 2'd1, S_HOLD = 2'd2} state_t;

   state_t        state_reg;
   logic [5:0]    scan_k_reg;
   logic [CW-1:0] pend_count_reg;
   logic [CW-1:0] act_count_reg;
   logic          pend_ovf_reg;
   logic [5:0]    pend_idx_reg  [MAX_SLOTS];
   logic [5:0]    act_idx_reg   [MAX_SLOTS];
   logic [15:0]   act_shape_reg [MAX_SLOTS];
   logic [9:0]    act_x_reg     [MAX_SLOTS];
   logic [7:0]    act_color_reg [MAX_SLOTS];

   logic          v_visible, render_en, at_load, frame_start;
   logic          eval_hit, eval_store, load_active;
   logic [9:0]    next_line, y_k, dy;
   logic [9:0]    slot_dx [MAX_SLOTS];
   logic [MAX_SLOTS-1:0] slot_hit;
   logic          win_found;
   logic [5:0]    win_id;
   logic [7:0]    win_color;

   assign v_visible   = (V_pos_in >= V_FIRST_L) && (V_pos_in <= V_LAST_L);
   assign render_en   = v_visible && (H_pos_in < H_ACTIVE_L);
   assign at_load     = (H_pos_in == LOAD_H_L);
   assign frame_start = (V_pos_in == 10'd0) && (H_pos_in == 10'd0);
   assign eval_state  = state_reg;

   // The >= guard keeps the 10-bit difference from wrapping for sprites near y=1023.
   assign next_line  = V_pos_in + 10'd1;
   assign y_k        = sprite_y[int'(scan_k_reg) * 10 +: 10];
   assign dy         = next_line - y_k;
   assign eval_hit   = (next_line >= y_k) && (dy <= 10'd15);
   assign eval_store = (state_reg == S_EVAL) && eval_hit && (pend_count_reg < MAX_L);
   assign load_active = (state_reg == S_HOLD) && at_load && v_visible;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= S_IDLE;
         scan_k_reg     <= '0;
         pend_count_reg <= '0;
         act_count_reg  <= '0;
         pend_ovf_reg   <= 1'b0;
         line_overflow  <= 1'b0;
         frame_overflow <= 1'b0;
      end else begin
         if (frame_start)
            frame_overflow <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (H_pos_in == EVAL_H_L && V_pos_in >= EVAL_LO_L && V_pos_in <= EVAL_HI_L) begin
                  state_reg      <= S_EVAL;
                  pend_count_reg <= '0;
                  pend_ovf_reg   <= 1'b0;
                  scan_k_reg     <= '0;
               end
               if (at_load) begin
                  act_count_reg <= '0;
                  line_overflow <= 1'b0;
               end
            end
            S_EVAL: begin
               if (eval_store)
                  pend_count_reg <= pend_count_reg + 1'b1;
               else if (eval_hit)
                  pend_ovf_reg <= 1'b1;
               scan_k_reg <= scan_k_reg + 6'd1;
               if (scan_k_reg == 6'd63)
                  state_reg <= S_HOLD;
            end
            S_HOLD: begin
               if (at_load) begin
                  state_reg <= S_IDLE;
                  if (v_visible) begin
                     act_count_reg <= pend_count_reg;
                     line_overflow <= pend_ovf_reg;
                     if (pend_ovf_reg)
                        frame_overflow <= 1'b1;
                  end else begin
                     act_count_reg <= '0;
                     line_overflow <= 1'b0;
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Slot storage carries no reset; act_count_reg alone decides which slots are live.
   always_ff @(posedge clk) begin
      for (int s = 0; s < MAX_SLOTS; s++) begin
         if (eval_store && pend_count_reg == CW'(s))
            pend_idx_reg[s] <= scan_k_reg;
         if (load_active) begin
            act_idx_reg[s]   <= pend_idx_reg[s];
            act_shape_reg[s] <= sprite_shape_in[int'(pend_idx_reg[s]) * 16 +: 16];
            act_x_reg[s]     <= sprite_x[int'(pend_idx_reg[s]) * 10 +: 10];
            act_color_reg[s] <= sprite_color[int'(pend_idx_reg[s]) * 8 +: 8];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < MAX_SLOTS; gi++) begin : g_slot
         assign slot_dx[gi]  = H_pos_in - act_x_reg[gi];
         assign slot_hit[gi] = (CW'(gi) < act_count_reg) && (H_pos_in >= act_x_reg[gi]) &&
                               (slot_dx[gi] < 10'd16) && act_shape_reg[gi][4'd15 - slot_dx[gi][3:0]];
      end
   endgenerate

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      win_color = '0;
      for (int s = MAX_SLOTS - 1; s >= 0; s--) begin
         if (slot_hit[s]) begin
            win_found = 1'b1;
            win_id    = act_idx_reg[s];
            win_color = act_color_reg[s];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pixel_valid     <= 1'b0;
         pixel_color     <= '0;
         pixel_sprite_id <= '0;
      end else begin
         pixel_valid     <= render_en && win_found;
         pixel_color     <= (render_en && win_found) ? win_color : 8'd0;
         pixel_sprite_id <= (render_en && win_found) ? win_id : 6'd0;
      end
   end

`ifdef SPRITE_COLLISION_DETECT_EN
   logic [1:0] hit_n;
   logic [5:0] hit_a, hit_b;

   always_comb begin
      hit_n = '0;
      hit_a = '0;
      hit_b = '0;
      for (int s = 0; s < MAX_SLOTS; s++) begin
         if (slot_hit[s]) begin
            if (hit_n == 2'd0)
               hit_a = act_idx_reg[s];
            else if (hit_n == 2'd1)
               hit_b = act_idx_reg[s];
            if (hit_n != 2'd2)
               hit_n = hit_n + 2'd1;
         end
      end
   end

   // Only the first collision of the frame is latched; later ones leave the ids untouched.
   always_ff @(posedge clk) begin
      if (!rst) begin
         collision_flag <= 1'b0;
         collision_id_a <= '0;
         collision_id_b <= '0;
      end else if (render_en && hit_n == 2'd2 && !(collision_flag && !frame_start)) begin
         collision_flag <= 1'b1;
         collision_id_a <= hit_a;
         collision_id_b <= hit_b;
      end else if (frame_start) begin
         collision_flag <= 1'b0;
         collision_id_a <= '0;
         collision_id_b <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_sprite_line_compositor.sv
// Bench for sprite_line_compositor: directed scenarios plus randomized sprite tables, checked against a line-level model.
module tb_sprite_line_compositor;
   localparam int NS = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [9:0]    V_pos_in, H_pos_in;
   logic [1023:0] sprite_shape_in;
   logic [639:0]  sprite_x, sprite_y;
   logic [511:0]  sprite_color;
   logic          pixel_valid, line_overflow, frame_overflow;
   logic [7:0]    pixel_color;
   logic [5:0]    pixel_sprite_id;
   logic [1:0]    eval_state;
`ifdef SPRITE_COLLISION_DETECT_EN
   logic          collision_flag;
   logic [5:0]    collision_id_a, collision_id_b;
`endif

   always #5 clk = ~clk;

   sprite_line_compositor dut (
      .clk(clk), .rst(rst), .V_pos_in(V_pos_in), .H_pos_in(H_pos_in),
      .sprite_shape_in(sprite_shape_in), .sprite_x(sprite_x), .sprite_y(sprite_y),
      .sprite_color(sprite_color), .pixel_valid(pixel_valid), .pixel_color(pixel_color),
      .pixel_sprite_id(pixel_sprite_id), .line_overflow(line_overflow),
      .frame_overflow(frame_overflow),
`ifdef SPRITE_COLLISION_DETECT_EN
      .collision_flag(collision_flag), .collision_id_a(collision_id_a),
      .collision_id_b(collision_id_b),
`endif
      .eval_state(eval_state)
   );

   int          tx [64];
   int          ty [64];
   int          tc [64];
   logic [15:0] tsh [64];
   int          sel [$];
   bit          ovf_exp, fo_exp, col_exp;
   int          col_a, col_b;
   int          checks = 0;
   int          failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int line, input int h,
                      input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s line=%0d h=%0d observed=%0h expected=%0h", tag, line, h, obs, expv);
      end
   endtask

   task automatic clear_tables();
      for (int k = 0; k < 64; k++) begin
         tx[k] = 3; ty[k] = 1000; tc[k] = 0; tsh[k] = 16'h0000;
      end
   endtask

   task automatic pack();
      for (int k = 0; k < 64; k++) begin
         sprite_shape_in[k*16 +: 16] = tsh[k];
         sprite_x[k*10 +: 10]        = 10'(tx[k]);
         sprite_y[k*10 +: 10]        = 10'(ty[k]);
         sprite_color[k*8 +: 8]      = 8'(tc[k]);
      end
   endtask

   // Visible sprites for a line: ascending index, first NS kept, any extra flags overflow.
   task automatic model_select(input int line, input bit ran);
      sel.delete();
      ovf_exp = 1'b0;
      if (ran) begin
         for (int k = 0; k < 64; k++) begin
            if (ty[k] <= line && line - ty[k] <= 15) begin
               if (sel.size() < NS) sel.push_back(k);
               else ovf_exp = 1'b1;
            end
         end
      end
   endtask

   task automatic exp_pix(input int line, input int h, output int v, output int id,
                          output int col, output int nhit, output int ida, output int idb);
      v = 0; id = 0; col = 0; nhit = 0; ida = 0; idb = 0;
      if (h < 640 && line >= 32 && line <= 511) begin
         foreach (sel[i]) begin
            int k;
            k = sel[i];
            if (h >= tx[k] && h - tx[k] < 16 && tsh[k][15 - (h - tx[k])]) begin
               if (nhit == 0) begin v = 1; id = k; col = tc[k]; ida = k; end
               else if (nhit == 1) idb = k;
               nhit++;
            end
         end
      end
   endtask

   task automatic clear_frame();
      V_pos_in = 10'd0; H_pos_in = 10'd0;
      tick();
      fo_exp = 1'b0; col_exp = 1'b0; col_a = 0; col_b = 0;
      chk("frame_ovf_clear", 0, 0, frame_overflow, 0);
`ifdef SPRITE_COLLISION_DETECT_EN
      chk("collision_clear", 0, 0, collision_flag, 0);
`endif
   endtask

   task automatic run_eval(input int prev);
      V_pos_in = 10'(prev); H_pos_in = 10'd640;
      tick();
      chk("state_eval_entry", prev, 640, eval_state, 1);
      chk("pix_off_h640", prev, 640, pixel_valid, 0);
      for (int i = 1; i < 64; i++) begin
         H_pos_in = 10'(640 + i);
         tick();
      end
      chk("state_eval_k63", prev, 703, eval_state, 1);
      H_pos_in = 10'd704;
      tick();
      chk("state_hold", prev, 704, eval_state, 2);
      H_pos_in = 10'd705;
      tick();
   endtask

   task automatic do_line(input int line, input bit do_eval);
      bit ran;
      int v, id, col, nhit, ida, idb;
      ran = do_eval && (line - 1 >= 31) && (line - 1 <= 510);
      if (do_eval) run_eval(line - 1);
      V_pos_in = 10'(line);
      for (int h = 0; h < 3; h++) begin
         H_pos_in = 10'(h);
         tick();
      end
      model_select(line, ran);
      if (ovf_exp) fo_exp = 1'b1;
      chk("line_overflow", line, 2, line_overflow, 32'(ovf_exp));
      chk("frame_overflow", line, 2, frame_overflow, 32'(fo_exp));
      chk("state_idle", line, 2, eval_state, 0);
      for (int h = 3; h < 640; h++) begin
         H_pos_in = 10'(h);
         tick();
         exp_pix(line, h, v, id, col, nhit, ida, idb);
         chk("pixel_valid", line, h, pixel_valid, 32'(v));
         chk("pixel_id", line, h, pixel_sprite_id, 32'(id));
         chk("pixel_color", line, h, pixel_color, 32'(col));
         if (nhit >= 2 && !col_exp) begin
            col_exp = 1'b1; col_a = ida; col_b = idb;
         end
      end
      H_pos_in = 10'd700;
      tick();
      chk("pix_off_h700", line, 700, pixel_valid, 0);
`ifdef SPRITE_COLLISION_DETECT_EN
      chk("collision_flag", line, 700, collision_flag, 32'(col_exp));
      chk("collision_id_a", line, 700, collision_id_a, 32'(col_a));
      chk("collision_id_b", line, 700, collision_id_b, 32'(col_b));
`endif
      $display("line %0d eval=%0d selected=%0d overflow=%0d", line, ran, sel.size(), ovf_exp);
   endtask

   initial begin
      rst = 1'b0;
      V_pos_in = 10'd100; H_pos_in = 10'd640;
      clear_tables();
      pack();
      tick();
      tick();
      chk("rst_state", 0, 0, eval_state, 0);
      chk("rst_valid", 0, 0, pixel_valid, 0);
      chk("rst_color", 0, 0, pixel_color, 0);
      chk("rst_id", 0, 0, pixel_sprite_id, 0);
      chk("rst_line_ovf", 0, 0, line_overflow, 0);
      chk("rst_frame_ovf", 0, 0, frame_overflow, 0);
      rst = 1'b1;
      H_pos_in = 10'd700;
      tick();

      // Single full-width sprite.
      clear_tables();
      ty[5] = 100; tx[5] = 200; tc[5] = 8'h3C; tsh[5] = 16'hFFFF;
      pack();
      clear_frame();
      do_line(100, 1'b1);

      // Two overlapping sprites: lower index wins.
      clear_tables();
      ty[3] = 40; tx[3] = 50; tc[3] = 8'h11; tsh[3] = 16'h8000;
      ty[9] = 40; tx[9] = 50; tc[9] = 8'h99; tsh[9] = 16'h8000;
      pack();
      clear_frame();
      do_line(45, 1'b1);

      // Ten sprites on one line overflow the slots; frame flag stays sticky.
      clear_tables();
      for (int k = 0; k < 10; k++) begin
         ty[k] = 60; tx[k] = 8 + k * 20; tc[k] = 16 + k; tsh[k] = 16'hF0F3;
      end
      pack();
      clear_frame();
      do_line(60, 1'b1);
      do_line(61, 1'b1);
      do_line(90, 1'b1);
      clear_frame();

      // y near 1023 never wraps; line 512 is outside the visible range.
      clear_tables();
      ty[0] = 1020; tx[0] = 20;  tc[0] = 8'h44; tsh[0] = 16'hFFFF;
      ty[1] = 511;  tx[1] = 100; tc[1] = 8'h55; tsh[1] = 16'hFFFF;
      pack();
      do_line(511, 1'b1);
      do_line(512, 1'b0);

      // Right-edge clipping.
      clear_tables();
      ty[12] = 300; tx[12] = 630; tc[12] = 8'hA5; tsh[12] = 16'hFFFF;
      pack();
      clear_frame();
      do_line(300, 1'b1);
      do_line(301, 1'b1);

      // Reset mid-scan on line 200.
      clear_tables();
      ty[7] = 195; tx[7] = 300; tc[7] = 8'h77; tsh[7] = 16'hA5A5;
      pack();
      clear_frame();
      V_pos_in = 10'd200; H_pos_in = 10'd640;
      tick();
      chk("state_eval_pre_rst", 200, 640, eval_state, 1);
      for (int h = 641; h < 660; h++) begin
         H_pos_in = 10'(h);
         tick();
      end
      rst = 1'b0;
      H_pos_in = 10'd660;
      tick();
      chk("state_after_rst", 200, 660, eval_state, 0);
      chk("frame_ovf_after_rst", 200, 660, frame_overflow, 0);
      rst = 1'b1;
      fo_exp = 1'b0; col_exp = 1'b0; col_a = 0; col_b = 0;
      for (int h = 661; h < 706; h++) begin
         H_pos_in = 10'(h);
         tick();
      end
      do_line(201, 1'b0);
      do_line(202, 1'b1);

      // Randomized sprite tables around a random line.
      for (int it = 0; it < 6; it++) begin
         int line;
         line = int'($urandom_range(40, 500));
         for (int k = 0; k < 64; k++) begin
            ty[k]  = ($urandom_range(0, 7) == 0) ? line - int'($urandom_range(0, 15))
                                                : int'($urandom_range(0, 1023));
            tx[k]  = int'($urandom_range(3, 639));
            tc[k]  = int'($urandom_range(0, 255));
            tsh[k] = 16'($urandom);
         end
         pack();
         clear_frame();
         do_line(line, 1'b1);
         do_line(line + 1, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
